// File: rtl/rr_mux_arbiter8.sv
// Round-robin arbiter sharing one 8:1 bit mux among eight requesters.
// Grants one owner for up to MAX_HOLD cycles, then rotates.
// Drives the registered select and grant, and the muxed data bit.
module rr_mux_arbiter8 #(
   parameter int unsigned NREQ     = 8,
   parameter int unsigned SEL_W    = $clog2(NREQ),
   parameter int unsigned MAX_HOLD = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [NREQ-1:0]  req,
   input  logic [NREQ-1:0]  data,
   output logic [NREQ-1:0]  gnt,
   output logic [SEL_W-1:0] sel,
   output logic             busy,
   output logic             y
);

   localparam int unsigned HC_W = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);

   typedef enum logic {
      IDLE,
      HOLD
   } state_t;

   state_t           state;
   logic [SEL_W-1:0] ptr;
   logic [HC_W-1:0]  hold_cnt;

   logic [NREQ-1:0]  cand;
   logic             found;
   logic [SEL_W-1:0] win;
   logic [SEL_W-1:0] idx;
   logic [SEL_W-1:0] ptr_nxt;
   logic             at_max;
   logic             take;
   logic             release_gnt;
   logic             renew;
   logic             bump;

   // Rotating search from ptr; the current owner is masked out so a rotation never reselects it.
   always_comb begin
      cand  = req & ~gnt;
      found = 1'b0;
      win   = '0;
      idx   = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         idx = SEL_W'((32'(ptr) + 32'(k)) % NREQ);
         if (!found && cand[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
      ptr_nxt = SEL_W'((32'(win) + 32'd1) % NREQ);
   end

   // Per-edge decision: new grant, release to idle, renew of a lone owner, or keep counting.
   always_comb begin
      take        = 1'b0;
      release_gnt = 1'b0;
      renew       = 1'b0;
      bump        = 1'b0;
      at_max      = (MAX_HOLD != 0) && (hold_cnt == HC_W'(MAX_HOLD));
      unique case (state)
         IDLE: take = found;
         HOLD: begin
            if (!req[sel]) begin
               take        = found;
               release_gnt = !found;
            end else if (at_max) begin
               take  = found;
               renew = !found;
            end else begin
               bump = 1'b1;
            end
         end
         default: take = 1'b0;
      endcase
   end

   // Arbiter state and registered grant/select.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         gnt      <= '0;
         sel      <= '0;
         busy     <= 1'b0;
         ptr      <= '0;
         hold_cnt <= '0;
      end else if (take) begin
         state    <= HOLD;
         gnt      <= NREQ'(1) << win;
         sel      <= win;
         busy     <= 1'b1;
         ptr      <= ptr_nxt;
         hold_cnt <= HC_W'(1);
      end else if (release_gnt) begin
         state <= IDLE;
         gnt   <= '0;
         busy  <= 1'b0;
      end else if (renew) begin
         hold_cnt <= HC_W'(1);
      end else if (bump && (hold_cnt != '1)) begin
         hold_cnt <= hold_cnt + HC_W'(1);
      end
   end

   // Shared 8:1 data mux, gated to zero while no grant is active.
   always_comb begin
      y = busy ? data[sel] : 1'b0;
   end

endmodule

// File: tb/tb_rr_mux_arbiter8.sv
// Self-checking bench for rr_mux_arbiter8: directed scenarios plus random
// traffic compared each cycle against a behavioural round-robin model.
module tb_rr_mux_arbiter8;

   localparam int MAX_HOLD = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] req;
   logic [7:0] data;
   logic [7:0] gnt;
   logic [2:0] sel;
   logic       busy;
   logic       y;

   int n_checks = 0;
   int n_pass   = 0;

   // Behavioural model: owner index (-1 = idle), search start, cycles held.
   int m_owner = -1;
   int m_ptr   = 0;
   int m_cnt   = 0;
   int m_sel   = 0;

   rr_mux_arbiter8 #(.NREQ(8), .SEL_W(3), .MAX_HOLD(MAX_HOLD)) dut (
      .clk  (clk),
      .reset(reset),
      .req  (req),
      .data (data),
      .gnt  (gnt),
      .sel  (sel),
      .busy (busy),
      .y    (y)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
   endtask

   function automatic int pick(input logic [7:0] r, input int start, input int excl);
      for (int k = 0; k < 8; k++) begin
         int i;
         i = (start + k) % 8;
         if (r[i] && i != excl) return i;
      end
      return -1;
   endfunction

   task automatic model_grant(input int w);
      m_owner = w;
      m_sel   = w;
      m_cnt   = 1;
      m_ptr   = (w + 1) % 8;
   endtask

   // Apply the arbitration rules to the values sampled at this edge.
   task automatic model_edge();
      int w;
      if (reset) begin
         m_owner = -1; m_ptr = 0; m_cnt = 0; m_sel = 0;
      end else if (m_owner < 0) begin
         w = pick(req, m_ptr, -1);
         if (w >= 0) model_grant(w);
      end else if (!req[m_owner]) begin
         w = pick(req, m_ptr, m_owner);
         if (w >= 0) model_grant(w);
         else m_owner = -1;
      end else if (MAX_HOLD != 0 && m_cnt == MAX_HOLD) begin
         w = pick(req, m_ptr, m_owner);
         if (w >= 0) model_grant(w);
         else m_cnt = 1;
      end else begin
         m_cnt++;
      end
   endtask

   task automatic check_model(input string tag);
      logic [7:0] eg;
      logic       ey;
      eg = (m_owner < 0) ? 8'h00 : (8'h01 << m_owner);
      ey = (m_owner < 0) ? 1'b0 : data[m_sel];
      check({tag, "_gnt"},  32'(gnt),  32'(eg));
      check({tag, "_sel"},  32'(sel),  32'(m_sel));
      check({tag, "_busy"}, 32'(busy), 32'(m_owner >= 0));
      check({tag, "_y"},    32'(y),    32'(ey));
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      check_model(tag);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step("rst");
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      req   = 8'h00;
      data  = 8'h00;
      @(negedge clk);

      // Reset state.
      do_reset();
      check("reset_gnt", 32'(gnt), 32'h0);
      check("reset_busy", 32'(busy), 32'h0);

      // 1: single requester, one-cycle latency.
      req = 8'h01; data = 8'h01;
      step("t1");
      check("t1_gnt", 32'(gnt), 32'h01);
      check("t1_y", 32'(y), 32'h1);

      // 2: all requesting -> owners 0..7,0 each for exactly MAX_HOLD cycles.
      do_reset();
      req = 8'hFF; data = 8'hA5;
      for (int n = 1; n <= 36; n++) begin
         logic [7:0] eg;
         step("t2");
         eg = 8'h01 << (((n - 1) / MAX_HOLD) % 8);
         check("t2_rot", 32'(gnt), 32'(eg));
      end

      // 3: wrap from owner 7 to owner 0.
      do_reset();
      req = 8'h80;
      step("t3");
      req = 8'h81;
      for (int n = 0; n < MAX_HOLD; n++) step("t3");
      check("t3_wrap", 32'(gnt), 32'h01);

      // 4: lone requester renews without a gap.
      do_reset();
      req = 8'h08;
      for (int n = 0; n < 10; n++) begin
         step("t4");
         check("t4_hold", 32'(gnt), 32'h08);
      end

      // 5: owner 2 drops, 4 and 5 pending -> 4 next.
      do_reset();
      req = 8'h04;
      step("t5");
      req = 8'h30;
      step("t5");
      check("t5_gnt", 32'(gnt), 32'h10);
      check("t5_sel", 32'(sel), 32'h4);
      req = 8'h20;
      step("t5");
      check("t5_ptr", 32'(gnt), 32'h20);

      // 6: reset mid-grant, search restarts at 0.
      req = 8'hFF; data = 8'hFF;
      for (int n = 0; n < 6; n++) step("t6");
      reset = 1'b1;
      step("t6");
      check("t6_rst_gnt", 32'(gnt), 32'h0);
      check("t6_rst_y", 32'(y), 32'h0);
      reset = 1'b0;
      req = 8'h0C;
      step("t6");
      check("t6_gnt", 32'(gnt), 32'h04);

      // Random traffic: requests change occasionally, data every cycle.
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 2) == 0) req = 8'($urandom) & 8'($urandom | $urandom);
         data  = 8'($urandom);
         reset = ($urandom_range(0, 60) == 0);
         #1;
         check("rnd_y_comb", 32'(y), 32'((m_owner < 0) ? 1'b0 : data[m_sel]));
         step("rnd");
         check("rnd_onehot", 32'($countones(gnt) <= 1), 32'h1);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
